// File: rtl/accum_arb_pkg.sv
// Shared types and width helpers for the accumulator round-robin arbiter.
// Holds the controller state encoding and default parameter values.
package accum_arb_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_ADD_WIDTH      = 32;
  localparam int DEF_ACCUM_WIDTH    = 2 * DEF_ADD_WIDTH;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    ACK     = 2'd3
  } state_t;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/accum_rr_arb.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr,
// wrapping at NUM_REQ.
module accum_rr_arb
  import accum_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               grant_valid
);

  logic [NUM_REQ-1:0] rotated;
  logic [IDX_W:0]     pos;

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    pos         = '0;
    // rotated[k] is requester (rr_ptr + k) mod NUM_REQ
    rotated     = NUM_REQ'({req, req} >> rr_ptr);
    // Walk downward so the smallest offset from rr_ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        pos         = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        grant_valid = 1'b1;
      end
    end
    if (pos >= (IDX_W+1)'(NUM_REQ)) begin
      pos = pos - (IDX_W+1)'(NUM_REQ);
    end
    grant = pos[IDX_W-1:0];
  end

endmodule

// File: rtl/accum_arbiter.sv
// Round-robin controller sharing one accumulator between NUM_REQ requesters.
// Optional phase watchdog with ack_err output: define ACCUM_ARB_TIMEOUT_EN.
module accum_arbiter
  import accum_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADD_WIDTH      = DEF_ADD_WIDTH,
  parameter int ACCUM_WIDTH    = 2 * ADD_WIDTH
`ifdef ACCUM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ADD_WIDTH-1:0] req_add,
  output logic [NUM_REQ-1:0]           ack,
  output logic [ACCUM_WIDTH-1:0]       ack_sum,
  output logic                         busy,
  output logic                         acc_en,
  output logic [ADD_WIDTH-1:0]         acc_add,
  input  logic [ACCUM_WIDTH-1:0]       acc_accum,
  input  logic                         acc_done
`ifdef ACCUM_ARB_TIMEOUT_EN
  ,
  output logic                         ack_err
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               acc_en_d;
  logic [ADD_WIDTH-1:0]   acc_add_d;
  logic [NUM_REQ-1:0]     ack_d;
  logic [ACCUM_WIDTH-1:0] ack_sum_d;

`ifdef ACCUM_ARB_TIMEOUT_EN
  localparam int CNT_W = idx_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_err_d;
  logic             timeout;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  accum_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .req         (req),
    .rr_ptr      (rr_ptr_q),
    .grant       (pick_idx),
    .grant_valid (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    acc_en_d  = acc_en;
    acc_add_d = acc_add;
    ack_d     = '0;
    ack_sum_d = ack_sum;
`ifdef ACCUM_ARB_TIMEOUT_EN
    cnt_d     = '0;
    ack_err_d = ack_err;
`endif

    unique case (state_q)
      IDLE: begin
        // A done still high here belongs to a handshake cut short by reset.
        if (!acc_done && pick_valid) begin
          grant_d   = pick_idx;
          acc_add_d = req_add[pick_idx*ADD_WIDTH +: ADD_WIDTH];
          acc_en_d  = 1'b1;
          state_d   = ISSUE;
        end
      end

      ISSUE: begin
`ifdef ACCUM_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (acc_done) begin
          acc_en_d = 1'b0;
          state_d  = RELEASE;
`ifdef ACCUM_ARB_TIMEOUT_EN
          cnt_d    = '0;
        end else if (timeout) begin
          acc_en_d       = 1'b0;
          ack_sum_d      = '0;
          ack_err_d      = 1'b1;
          ack_d[grant_q] = 1'b1;
          state_d        = ACK;
`endif
        end
      end

      RELEASE: begin
`ifdef ACCUM_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (!acc_done) begin
          ack_sum_d      = acc_accum;
          ack_d[grant_q] = 1'b1;
          state_d        = ACK;
`ifdef ACCUM_ARB_TIMEOUT_EN
          ack_err_d      = 1'b0;
        end else if (timeout) begin
          ack_sum_d      = '0;
          ack_err_d      = 1'b1;
          ack_d[grant_q] = 1'b1;
          state_d        = ACK;
`endif
        end
      end

      ACK: begin
        rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      acc_en   <= 1'b0;
      acc_add  <= '0;
      ack      <= '0;
      ack_sum  <= '0;
      busy     <= 1'b0;
`ifdef ACCUM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      ack_err  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      acc_en   <= acc_en_d;
      acc_add  <= acc_add_d;
      ack      <= ack_d;
      ack_sum  <= ack_sum_d;
      busy     <= (state_d != IDLE);
`ifdef ACCUM_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      ack_err  <= ack_err_d;
`endif
    end
  end

endmodule
